sdram_read_sched: RTL and testbench
===================================

Name: sdram_read_sched

Overview:
- Round-robin scheduler that shares the single SDRAM Avalon-MM read port among up to 32 EU-group fetch engines.
- Drives the 5-bit select of the SDRAM read mux and owns the port for one whole burst, tracking accepted commands and returned beats.
- Releases the port only when the granted requester's transfer has fully drained, then signals completion to that requester.
- Sits between the control unit and the SDRAM read mux inside the EU top level.

Parameters:
- NUM_REQ, 4, number of requesters (1..32); requester i maps to mux port i.
- LEN_W, 16, width of per-request beat count.
- TIMEOUT, 1024, idle-beat watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req  in  NUM_REQ  per-requester fetch request, level; held until its done pulse.
- req_len  in  NUM_REQ*LEN_W  beat count per requester; slice i = bits [i*LEN_W +: LEN_W]. Sampled at grant.
- grant  out  NUM_REQ  one-hot current owner; all-zero when idle.
- sel  out  5  mux select, zero-extended index of the owner.
- cmd_allow  out  1  high while the owner may still issue read commands (issued < len).
- done  out  NUM_REQ  one-cycle pulse to the owner at release.
- busy  out  1  port owned.
- rd_cmd_acc  in  1  read && !waitrequest observed on the muxed bus.
- rd_valid  in  1  readdatavalid observed on the muxed bus.
- err  out  1  sticky watchdog error (optional feature only; tied 0 otherwise).

Behaviour:
- Reset: state=IDLE; grant=0; sel=0; cmd_allow=0; done=0; busy=0; err=0; rr_ptr=0; counters=0. Reset mid-burst abandons the burst immediately with no done pulse.
- States: IDLE, GRANT, DRAIN, RELEASE.
- IDLE, any req high:
  - Pick the first requester at or after rr_ptr, wrapping modulo NUM_REQ.
  - Latch len = req_len slice; set grant/sel/busy next cycle; go to GRANT.
  - Grant latency is 1 cycle from req.
- GRANT:
  - cmd_allow = (issued_cnt < len).
  - issued_cnt increments on rd_cmd_acc; rcv_cnt increments on rd_valid.
  - When issued_cnt reaches len, go to DRAIN.
  - rd_cmd_acc while issued_cnt == len is a protocol violation; ignore it, counter saturates.
- DRAIN: cmd_allow=0; when rcv_cnt == len (counting a same-cycle rd_valid), go to RELEASE.
- len == 0: GRANT goes directly to RELEASE; no commands allowed.
- RELEASE, one cycle:
  - done[owner]=1; grant and sel still held.
  - rr_ptr = (owner+1) mod NUM_REQ.
  - Next state IDLE: grant=0, busy=0, sel returns to 0.
- Minimum gap between two grants is 1 idle cycle, so the mux never switches with beats in flight.
- Requester dropping req while granted has no effect; the burst completes.
- rd_valid in IDLE or RELEASE is ignored.
- Counters are LEN_W bits and never wrap; rcv_cnt saturates at len.
- Simultaneous rd_cmd_acc and rd_valid in one cycle: both counters update.
- Requesters with index >= NUM_REQ do not exist; sel never exceeds NUM_REQ-1.

Optional Feature:
- Macro: SDRAM_RD_TIMEOUT_EN.
- Defined:
  - A watchdog counts consecutive GRANT/DRAIN cycles with neither rd_cmd_acc nor rd_valid.
  - At TIMEOUT it sets err (sticky until rst) and forces RELEASE; done still pulses so the requester unblocks.
- Undefined: no watchdog logic, err tied 0, a stalled burst holds the port indefinitely.

Test Plan:
- Single requester: req[0]=1, len=4; 4 accepts then 4 valids → grant=0001 1 cycle after req; cmd_allow falls after 4th accept; done[0] pulses 1 cycle after 4th valid; busy low the cycle after.
- Round-robin: req=1111 held, each len=2 → grant order 0,1,2,3,0; sel tracks 0,1,2,3,0; 1 idle cycle between grants.
- Pointer wrap: after owner 3 releases, only req[1] and req[2] high → grant goes to 1, not 2.
- Zero length: req[2]=1, len=0 → grant 0100, cmd_allow never high, done[2] pulses the cycle after GRANT.
- Overlap and reset: len=8, accepts and valids interleaved with same-cycle events → done only after 8th valid; separately, rst asserted after 3 valids → all outputs 0 next cycle, no done.
- With SDRAM_RD_TIMEOUT_EN, TIMEOUT=16: len=4, only 2 valids then silence → err=1 and done[0] pulse 16 cycles after the last beat; err stays 1 until rst.

Source files
------------

// File: rtl/sdram_read_sched.sv
// sdram_read_sched
//   Round-robin owner of the shared SDRAM Avalon-MM read port. One requester
//   at a time is granted the port for a whole burst. The port is held until
//   every accepted command has returned its beat, and only then is the owner
//   released with a one-cycle done pulse.
//
// Parameters
//   NUM_REQ  number of requesters (1..32); requester i drives mux port i
//   LEN_W    width of the per-request beat count
//   TIMEOUT  idle-cycle watchdog limit (SDRAM_RD_TIMEOUT_EN builds only, >= 2)
//
// Ports
//   i_clk, i_rst     clock, synchronous active-high reset
//   i_req            per-requester level request, held until its done pulse
//   i_req_len        beat count per requester, slice i at [i*LEN_W +: LEN_W]
//   o_grant          one-hot current owner, zero when idle
//   o_sel            mux select (owner index), zero when idle
//   o_cmd_allow      owner may still issue read commands
//   o_done           one-cycle pulse to the owner at release
//   o_busy           port owned
//   i_rd_cmd_acc     read command accepted on the muxed bus
//   i_rd_valid       read beat returned on the muxed bus
//   o_err            sticky watchdog error
//
// Build option
//   SDRAM_RD_TIMEOUT_EN  adds the stalled-burst watchdog. Without it o_err is
//                        tied low and a stalled burst keeps the port.
//
// state   | meaning
// IDLE    | port free, arbitrating among pending requests
// GRANT   | owner issuing commands, beats may already be returning
// DRAIN   | all commands issued, waiting for the remaining beats
// RELEASE | one cycle: done to owner, round-robin pointer advances

module sdram_read_sched #(
  parameter int NUM_REQ = 4,
  parameter int LEN_W   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NUM_REQ-1:0]       i_req,
  input  logic [NUM_REQ*LEN_W-1:0] i_req_len,
  output logic [NUM_REQ-1:0]       o_grant,
  output logic [4:0]               o_sel,
  output logic                     o_cmd_allow,
  output logic [NUM_REQ-1:0]       o_done,
  output logic                     o_busy,
  input  logic                     i_rd_cmd_acc,
  input  logic                     i_rd_valid,
  output logic                     o_err
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_DRAIN   = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  localparam logic [4:0]       LAST_IDX = 5'(NUM_REQ - 1);
  localparam logic [LEN_W-1:0] CNT_ONE  = 1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [4:0]       r_owner;
  logic [4:0]       r_rr_ptr;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_issued;
  logic [LEN_W-1:0] r_rcv;

  logic             w_found_hi;
  logic [4:0]       w_pick_hi;
  logic [LEN_W-1:0] w_len_hi;
  logic [4:0]       w_pick_any;
  logic [LEN_W-1:0] w_len_any;
  logic [4:0]       w_pick;
  logic [LEN_W-1:0] w_pick_len;

  logic [LEN_W-1:0] w_issued_nxt;
  logic [LEN_W-1:0] w_rcv_nxt;
  logic             w_timeout;

  // Round-robin pick: the lowest requester at or above the pointer wins,
  // otherwise the lowest requester overall (the wrap-around case). Scanning
  // downward lets the last hit be the lowest index.
  always_comb begin
    w_found_hi = 1'b0;
    w_pick_hi  = '0;
    w_len_hi   = '0;
    w_pick_any = '0;
    w_len_any  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        w_pick_any = 5'(i);
        w_len_any  = i_req_len[i*LEN_W +: LEN_W];
        if (5'(i) >= r_rr_ptr) begin
          w_found_hi = 1'b1;
          w_pick_hi  = 5'(i);
          w_len_hi   = i_req_len[i*LEN_W +: LEN_W];
        end
      end
    end
    w_pick     = w_found_hi ? w_pick_hi : w_pick_any;
    w_pick_len = w_found_hi ? w_len_hi  : w_len_any;
  end

  // Both counters saturate at len: stray accepts after the last command and
  // extra beats are ignored rather than wrapping.
  always_comb begin
    w_issued_nxt = r_issued;
    w_rcv_nxt    = r_rcv;
    if (i_rd_cmd_acc && (r_issued != r_len)) w_issued_nxt = r_issued + CNT_ONE;
    if (i_rd_valid && (r_rcv != r_len))      w_rcv_nxt    = r_rcv + CNT_ONE;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_owner  <= '0;
      r_rr_ptr <= '0;
      r_len    <= '0;
      r_issued <= '0;
      r_rcv    <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (|i_req) begin
            r_owner  <= w_pick;
            r_len    <= w_pick_len;
            r_issued <= '0;
            r_rcv    <= '0;
          end
        end
        S_GRANT, S_DRAIN: begin
          r_issued <= w_issued_nxt;
          r_rcv    <= w_rcv_nxt;
        end
        S_RELEASE: begin
          r_rr_ptr <= (r_owner == LAST_IDX) ? 5'd0 : r_owner + 5'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_grant     = '0;
    o_done      = '0;
    o_sel       = '0;
    o_busy      = 1'b0;
    o_cmd_allow = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (|i_req) w_state_nxt = S_GRANT;
      end
      S_GRANT: begin
        // A zero-length grant, or a burst whose final beat lands together
        // with its final accept, skips DRAIN.
        if (w_timeout)
          w_state_nxt = S_RELEASE;
        else if (w_issued_nxt == r_len)
          w_state_nxt = (w_rcv_nxt == r_len) ? S_RELEASE : S_DRAIN;
      end
      S_DRAIN: begin
        if (w_timeout || (w_rcv_nxt == r_len)) w_state_nxt = S_RELEASE;
      end
      S_RELEASE: begin
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (r_state != S_IDLE) begin
      o_busy = 1'b1;
      o_sel  = r_owner;
      for (int i = 0; i < NUM_REQ; i++) o_grant[i] = (r_owner == 5'(i));
    end
    if (r_state == S_GRANT)   o_cmd_allow = (r_issued < r_len);
    if (r_state == S_RELEASE) o_done      = o_grant;
  end

`ifdef SDRAM_RD_TIMEOUT_EN
  // Down-counter reloaded on any bus activity and outside a burst. Terminal
  // count on an idle cycle forces RELEASE, so err and done appear TIMEOUT
  // cycles after the last activity.
  localparam int            WD_W    = $clog2(TIMEOUT) + 1;
  localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT - 2);

  logic [WD_W-1:0] r_wd_cnt;
  logic            r_err;
  logic            w_bus_idle;
  logic            w_in_burst;

  assign w_bus_idle = !i_rd_cmd_acc && !i_rd_valid;
  assign w_in_burst = (r_state == S_GRANT) || (r_state == S_DRAIN);
  assign w_timeout  = w_in_burst && w_bus_idle && (r_wd_cnt == '0);
  assign o_err      = r_err;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wd_cnt <= WD_LOAD;
      r_err    <= 1'b0;
    end else begin
      if (!w_in_burst || !w_bus_idle)
        r_wd_cnt <= WD_LOAD;
      else if (r_wd_cnt != '0)
        r_wd_cnt <= r_wd_cnt - 1'b1;
      if (w_timeout) r_err <= 1'b1;
    end
  end
`else
  // Without the watchdog TIMEOUT has no effect; this compare is always false.
  assign w_timeout = 1'b0;
  assign o_err     = (TIMEOUT < 0);
`endif

endmodule

// File: tb/tb_sdram_read_sched.sv
module tb_sdram_read_sched;

  localparam int N  = 4;
  localparam int LW = 16;
  localparam logic [N-1:0] ONE_N = 1;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*LW-1:0] req_len;
  logic [N-1:0]    grant;
  logic [4:0]      sel;
  logic            cmd_allow;
  logic [N-1:0]    done;
  logic            busy;
  logic            rd_cmd_acc;
  logic            rd_valid;
  logic            err;

  sdram_read_sched #(.NUM_REQ(N), .LEN_W(LW), .TIMEOUT(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_req_len(req_len),
    .o_grant(grant), .o_sel(sel), .o_cmd_allow(cmd_allow), .o_done(done),
    .o_busy(busy), .i_rd_cmd_acc(rd_cmd_acc), .i_rd_valid(rd_valid), .o_err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int owner;
    int len;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   model_ptr = 0;
  int   blen[N];
  bit   abort = 0;

  // ---------------- bus responder ----------------
  int inflight;
  initial begin
    rd_cmd_acc = 1'b0;
    rd_valid   = 1'b0;
    inflight   = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        rd_cmd_acc = 1'b0;
        rd_valid   = 1'b0;
        inflight   = 0;
      end else begin
        rd_valid = 1'b0;
        if (inflight > 0 && $urandom_range(0, 2) != 0) begin
          rd_valid = 1'b1;
          inflight--;
        end else if (!busy && inflight == 0 && $urandom_range(0, 7) == 0) begin
          rd_valid = 1'b1;  // stray beat while idle, must be ignored
        end
        rd_cmd_acc = cmd_allow && ($urandom_range(0, 3) != 0);
        if (rd_cmd_acc) inflight++;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int   cyc = 0;
  bit   in_burst = 0;
  bit   prev_done = 0;
  int   acc_cnt, rcv_cnt, start_cyc, last_valid_cyc, exp_cyc;
  exp_t e;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      in_burst  = 0;
      prev_done = 0;
    end else begin
      if (prev_done) begin
        tests++;
        if (busy) begin
          fails++;
          $display("FAIL release_gap: busy=%0b the cycle after done, required 0", busy);
        end
      end
      prev_done = (done != '0);

      if (busy && !in_burst) begin
        in_burst       = 1;
        acc_cnt        = 0;
        rcv_cnt        = 0;
        start_cyc      = cyc;
        last_valid_cyc = -100;
      end

      if (in_burst && exp_q.size() > 0) begin
        e = exp_q[0];
        tests++;
        if (grant !== (ONE_N << e.owner) || sel !== 5'(e.owner) ||
            cmd_allow !== (acc_cnt < e.len)) begin
          fails++;
          $display("FAIL burst_outputs: grant=%b sel=%0d cmd_allow=%0b, required grant=%b sel=%0d cmd_allow=%0b",
                   grant, sel, cmd_allow, ONE_N << e.owner, e.owner, (acc_cnt < e.len));
        end
      end

      if (done != '0) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_done: done=%b, required 0000", done);
        end else begin
          e = exp_q.pop_front();
          exp_cyc = (e.len == 0) ? start_cyc + 1 : last_valid_cyc + 1;
          if (done !== (ONE_N << e.owner) || acc_cnt != e.len || rcv_cnt != e.len ||
              cyc != exp_cyc || err !== 1'b0) begin
            fails++;
            $display("FAIL done_check: done=%b accepts=%0d beats=%0d at_cycle=%0d err=%0b, required done=%b accepts=%0d beats=%0d at_cycle=%0d err=0",
                     done, acc_cnt, rcv_cnt, cyc, err, ONE_N << e.owner, e.len, e.len, exp_cyc);
          end
        end
        in_burst = 0;
      end else if (in_burst) begin
        if (rd_cmd_acc) acc_cnt++;
        if (rd_valid) begin
          rcv_cnt++;
          last_valid_cyc = cyc;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_idle_outputs(input string name);
    tests++;
    if (grant !== '0 || sel !== '0 || cmd_allow !== 1'b0 || done !== '0 ||
        busy !== 1'b0 || err !== 1'b0) begin
      fails++;
      $display("FAIL %s: grant=%b sel=%0d cmd_allow=%0b done=%b busy=%0b err=%0b, required all zero",
               name, grant, sel, cmd_allow, done, busy, err);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    req = '0;
    @(posedge clk);
    #1;
    check_idle_outputs("reset_outputs");
    @(posedge clk);
    #3;
    rst = 1'b0;
    model_ptr = 0;
  endtask

  // Expected service order from the rules: pending requesters are served in
  // increasing distance from the round-robin pointer, modulo N.
  task automatic run_batch(input logic [N-1:0] mask);
    int first;
    int last;
    int budget;
    if (mask == '0 || abort) return;
    first = -1;
    last  = 0;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (model_ptr + k) % N;
      if (mask[i]) begin
        exp_q.push_back('{owner: i, len: blen[i]});
        if (first < 0) first = i;
        last = i;
      end
    end
    model_ptr = (last + 1) % N;
    req_len = '0;
    for (int i = 0; i < N; i++) req_len = req_len | ((N*LW)'(blen[i]) << (i * LW));

    @(posedge clk);
    #1;
    req = mask;
    @(posedge clk);
    #1;
    tests++;
    if (busy !== 1'b1 || grant !== (ONE_N << first)) begin
      fails++;
      $display("FAIL grant_latency: busy=%0b grant=%b, required busy=1 grant=%b",
               busy, grant, ONE_N << first);
    end
    budget = 3000;
    while (req != '0) begin
      if (done != '0) req = req & ~done;
      if (req == '0) break;
      budget--;
      if (budget == 0) begin
        tests++;
        fails++;
        $display("FAIL batch_timeout: pending req=%b, required 0000", req);
        abort = 1;
        return;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic reset_mid_burst();
    int nvalid;
    int budget;
    if (abort) return;
    blen = '{0, 0, 8, 0};
    req_len = '0;
    req_len[2*LW +: LW] = 16'd8;
    @(posedge clk);
    #1;
    req = 4'b0100;
    nvalid = 0;
    budget = 1000;
    while (nvalid < 3 && budget > 0) begin
      @(negedge clk);
      if (busy && done == '0 && rd_valid) nvalid++;
      budget--;
    end
    tests++;
    if (nvalid < 3) begin
      fails++;
      $display("FAIL reset_setup: beats=%0d, required 3", nvalid);
      abort = 1;
      return;
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    req = '0;
    @(posedge clk);
    #1;
    check_idle_outputs("reset_mid_burst");
    @(posedge clk);
    #3;
    rst = 1'b0;
    model_ptr = 0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst     = 1'b1;
    req     = '0;
    req_len = '0;
    do_reset();

    blen = '{4, 0, 0, 0};  run_batch(4'b0001);   // single requester
    blen = '{2, 2, 2, 2};  run_batch(4'b1111);   // round robin 1,2,3,0 from ptr 1
    blen = '{2, 2, 2, 2};  run_batch(4'b1111);   // ptr back at 1
    blen = '{0, 0, 0, 3};  run_batch(4'b1000);   // owner 3, ptr wraps to 0
    blen = '{0, 2, 2, 0};  run_batch(4'b0110);   // grant goes to 1 first
    blen = '{0, 0, 0, 0};  run_batch(4'b0100);   // zero length
    blen = '{0, 8, 0, 0};  run_batch(4'b0010);   // long interleaved burst

    reset_mid_burst();
    blen = '{1, 1, 1, 1};  run_batch(4'b1111);   // pointer restarted at 0

    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < N; i++) blen[i] = $urandom_range(0, 6);
      run_batch(4'($urandom_range(1, 15)));
    end

    repeat (5) @(posedge clk);
    #1;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d bursts outstanding, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
